spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  the single clock; MOSI sampled and MISO driven on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; high frames end a transaction.
REQ-005 MOSI  input  1  serial data from the master, MSB first.
REQ-006 MISO  output  1  serial read data to the master, MSB first.
REQ-007 rx_data  output  10  assembled command word: [9:8] opcode, [7:0] address or data.
REQ-008 rx_valid  output  1  one-cycle strobe that rx_data is complete.
REQ-009 tx_data  input  8  read data returned by the memory.
REQ-010 tx_valid  input  1  tx_data is valid in this cycle.

Function
REQ-011 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, held in a registered state variable.
REQ-012 IDLE SHALL go to CHK_CMD when SS_n=0; otherwise it SHALL stay in IDLE.
REQ-013 CHK_CMD SHALL sample MOSI as a select bit that is not stored: MOSI=0 goes to WRITE; MOSI=1 goes to READ_ADD when rd_addr_received=0 and to READ_DATA when rd_addr_received=1.
REQ-014 WRITE, READ_ADD and READ_DATA SHALL each shift in exactly 10 MOSI bits, one per clk, MSB first, into a 10-bit shift register using a 4-bit counter (0..9).
REQ-015 On the edge that samples the 10th bit, rx_data SHALL load the full word, and rx_valid SHALL be 1 for exactly the following cycle; rx_data SHALL hold its value until the next completed word.
REQ-016 Latency: with SS_n falling before edge E0, the select bit is sampled at E1, data bits at E2..E11, and rx_valid is high in the cycle after E11.
REQ-017 rx_data[9:8] SHALL be forwarded exactly as received; the state (WRITE, READ_ADD or READ_DATA) SHALL NOT alter the opcode bits.
REQ-018 After rx_valid, WRITE and READ_ADD SHALL remain in place, ignoring MOSI, until SS_n=1.
REQ-019 rd_addr_received SHALL be set when the rx_valid of a READ_ADD word is issued.
REQ-020 In READ_DATA, after rx_valid, the module SHALL wait indefinitely, while SS_n=0, for tx_valid=1.
REQ-021 On the first edge sampling tx_valid=1, tx_data SHALL be captured in an 8-bit register; tx_valid at any other time SHALL be ignored.
REQ-022 MISO SHALL present captured bit 7 in the cycle after capture, then bits 6..0 on successive cycles, for 8 cycles total.
REQ-023 After the 8th bit, MISO SHALL return to 0, rd_addr_received SHALL clear, and the FSM SHALL stay in READ_DATA until SS_n=1.
REQ-024 MISO SHALL be 0 in every state and cycle other than the 8 serialisation cycles.
REQ-025 SS_n=1 sampled in any non-IDLE state SHALL cause a return to IDLE on that edge.
REQ-026 That abort SHALL clear the bit counter, the serialisation counter and any pending tx capture, issue no rx_valid, and drive MISO=0.
REQ-027 rd_addr_received SHALL NOT change on an abort.
REQ-028 If SS_n rises on the same edge as the 10th bit, the abort SHALL win: no rx_valid, and rx_data unchanged.
REQ-029 READ_DATA entered with rd_addr_received=1 is the only path to serialisation.
REQ-030 A word with opcode 2'b11 received via READ_ADD SHALL still be forwarded, and serialisation SHALL NOT start.

Reset
REQ-031 rst_n=0 SHALL, without waiting for clk, force the state to IDLE and all of the following to 0: rx_data, rx_valid, MISO, rd_addr_received, both counters and the capture register.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction, and no rx_valid SHALL appear after rst_n rises.
REQ-033 After rst_n rises, the first transaction SHALL require a new SS_n low while in IDLE.

Verification
REQ-034 Write address: SS_n=0, select 0, bits 00_1010_0101 -> rx_data=10'h0A5 and rx_valid for 1 cycle after the 10th bit; no MISO activity.
REQ-035 Read address then read data: select 1, 10_0011_1100 -> rx_data=10'h23C and rd_addr_received=1; SS_n high; select 1, 11_0000_0000 -> rx_data=10'h300; tx_valid=1 with tx_data=8'hC3 -> MISO=1,1,0,0,0,0,1,1 then 0; rd_addr_received=0.
REQ-036 Abort: SS_n rises after 6 data bits -> IDLE next edge, no rx_valid, rx_data unchanged; the next full frame decodes correctly.
REQ-037 Asynchronous reset during serialisation of 8'hFF after 3 bits -> MISO=0 immediately, state IDLE, rd_addr_received=0.
REQ-038 Stray tx_valid=1 with tx_data=8'h55 in IDLE and WRITE -> MISO stays 0 throughout.
REQ-039 SS_n rising on the 10th-bit edge -> no rx_valid.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end: decodes a select bit plus a 10-bit command word from
// MOSI, forwards it on rx_data/rx_valid, and serialises one byte of memory
// read data back on MISO after a read-address / read-data frame pair.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data (no
// back-pressure); tx_valid is sampled only while a READ_DATA frame is waiting
// for its byte, and the first cycle it is high captures tx_data.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;

    // The first nine bits of a word are held here; the tenth is taken
    // straight from MOSI on the completing edge to form the full word.
    logic [8:0] shift_q;
    logic [3:0] bit_cnt;
    logic       word_done;
    logic       rd_addr_received;
    logic [7:0] tx_buf;
    logic [3:0] ser_cnt;
    logic       ser_busy;
    logic       rx_state;

    assign rx_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; SS_n high in any active state returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)                  state_next = IDLE;
                else if (!MOSI)            state_next = WRITE;
                else if (rd_addr_received) state_next = READ_DATA;
                else                       state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word assembly, read-address flag, byte capture and MISO serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q          <= '0;
            bit_cnt          <= '0;
            word_done        <= 1'b0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rd_addr_received <= 1'b0;
            tx_buf           <= '0;
            ser_cnt          <= '0;
            ser_busy         <= 1'b0;
            MISO             <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || !rx_state) begin
                // Outside a data phase (or aborting one): drop all progress.
                // rd_addr_received deliberately survives an abort.
                bit_cnt   <= '0;
                word_done <= 1'b0;
                ser_cnt   <= '0;
                ser_busy  <= 1'b0;
                tx_buf    <= '0;
                MISO      <= 1'b0;
            end else if (!word_done) begin
                shift_q <= {shift_q[7:0], MOSI};
                if (bit_cnt == 4'd9) begin
                    rx_data   <= {shift_q, MOSI};
                    rx_valid  <= 1'b1;
                    word_done <= 1'b1;
                    bit_cnt   <= '0;
                    if (state == READ_ADD) rd_addr_received <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (state == READ_DATA && rd_addr_received) begin
                if (ser_busy) begin
                    if (ser_cnt == 4'd8) begin
                        MISO             <= 1'b0;
                        ser_busy         <= 1'b0;
                        ser_cnt          <= '0;
                        rd_addr_received <= 1'b0;
                    end else begin
                        MISO    <= tx_buf[3'd7 - ser_cnt[2:0]];
                        ser_cnt <= ser_cnt + 4'd1;
                    end
                end else if (tx_valid) begin
                    // Bit 7 goes out on the capture edge itself.
                    tx_buf   <= tx_data;
                    MISO     <= tx_data[7];
                    ser_busy <= 1'b1;
                    ser_cnt  <= 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames followed by randomised frames, with a
// frame-level reference model predicting rx_data/rx_valid/MISO every cycle.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs must be after the next edge.
    logic       exp_valid = 1'b0;
    logic       exp_miso = 1'b0;
    logic [9:0] exp_rx_data = 10'h000;
    logic       model_rd = 1'b0;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs were set at the previous falling edge; outputs are
    // compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("rx_valid", 10'(rx_valid), 10'(exp_valid));
        check("miso", 10'(MISO), 10'(exp_miso));
        check("rx_data", rx_data, exp_rx_data);
    endtask

    task automatic check_rd(input string tag);
        check(tag, 10'(dut.rd_addr_received), 10'(model_rd));
    endtask

    // SS_n high with stray tx_valid/tx_data=55 and junk MOSI.
    task automatic idle(input int n);
        SS_n = 1'b1;
        for (int k = 0; k < n; k++) begin
            MOSI = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data = 8'h55;
            tick();
        end
        tx_valid = 1'b0;
    endtask

    // Select bit plus word. abort_bit in 0..9 raises SS_n on that data-bit
    // edge instead of completing; 10 means a full word.
    // path: 0 write, 1 read address, 2 read data.
    task automatic send_word(input logic sel, input logic [9:0] word, input int abort_bit,
                             output int path, output bit aborted);
        aborted = 1'b0;
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data = 8'($urandom);
        tick();
        MOSI = sel;
        tick();
        path = !sel ? 0 : (model_rd ? 2 : 1);
        for (int i = 0; i < 10; i++) begin
            MOSI = word[9-i];
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
            if (i == abort_bit) begin
                SS_n = 1'b1;
                tick();
                aborted = 1'b1;
                return;
            end
            if (i == 9) begin
                exp_valid = 1'b1;
                exp_rx_data = word;
                if (path == 1) model_rd = 1'b1;
            end
            tick();
        end
        exp_valid = 1'b0;
    endtask

    // Full frame. ser_abort in 1..8 raises SS_n on that serialisation edge.
    task automatic frame(input logic sel, input logic [9:0] word, input int abort_bit,
                         input bit give_tx, input logic [7:0] txd, input int tx_delay,
                         input int ser_abort, input int linger);
        int path;
        bit aborted;
        send_word(sel, word, abort_bit, path, aborted);
        check_rd("rd_after_word");
        if (aborted) return;
        if (path != 2) begin
            for (int k = 0; k < linger; k++) begin
                MOSI = 1'($urandom);
                tx_valid = 1'($urandom);
                tx_data = 8'h55;
                tick();
            end
        end else begin
            tx_valid = 1'b0;
            for (int k = 0; k < tx_delay; k++) begin
                MOSI = 1'($urandom);
                tx_data = 8'($urandom);
                tick();
            end
            if (give_tx) begin
                tx_valid = 1'b1;
                tx_data = txd;
                exp_miso = txd[7];
                tick();
                for (int j = 1; j <= 8; j++) begin
                    tx_valid = 1'($urandom);
                    tx_data = 8'($urandom);
                    MOSI = 1'($urandom);
                    if (j == ser_abort) begin
                        SS_n = 1'b1;
                        exp_miso = 1'b0;
                        tick();
                        check_rd("rd_ser_abort");
                        return;
                    end
                    if (j < 8) begin
                        exp_miso = txd[7-j];
                    end else begin
                        exp_miso = 1'b0;
                        model_rd = 1'b0;
                    end
                    tick();
                end
                check_rd("rd_after_ser");
            end
            for (int k = 0; k < linger; k++) begin
                tx_valid = give_tx ? 1'($urandom) : 1'b0;
                tx_data = 8'($urandom);
                tick();
            end
        end
        SS_n = 1'b1;
        tx_valid = 1'b0;
        tick();
        check_rd("rd_end_frame");
    endtask

    // Stimulus, reset checks, directed cases, random frames and report.
    initial begin
        int path;
        bit aborted;

        #2;
        check("rst_miso", 10'(MISO), 10'd0);
        check("rst_rx_valid", 10'(rx_valid), 10'd0);
        check("rst_rx_data", rx_data, 10'd0);
        check_rd("rst_rd");
        tick();
        tick();
        rst_n = 1'b1;
        idle(3);

        // Write address 0A5.
        frame(1'b0, 10'h0A5, 10, 1'b0, 8'h00, 0, 0, 3);
        idle(2);
        // Read address 23C, then read data 300 returning C3.
        frame(1'b1, 10'h23C, 10, 1'b0, 8'h00, 0, 0, 2);
        check_rd("rd_set_23c");
        idle(1);
        frame(1'b1, 10'h300, 10, 1'b1, 8'hC3, 2, 0, 2);
        check_rd("rd_clear_300");
        idle(2);
        // Abort after six data bits, then a clean frame.
        frame(1'b0, 10'h155, 6, 1'b0, 8'h00, 0, 0, 0);
        idle(2);
        frame(1'b0, 10'h2AA, 10, 1'b0, 8'h00, 0, 0, 2);
        idle(1);
        // SS_n rising on the 10th-bit edge.
        frame(1'b0, 10'h3FF, 9, 1'b0, 8'h00, 0, 0, 0);
        idle(2);
        // Opcode 11 via read address: forwarded, no serialisation.
        frame(1'b1, 10'h3F0, 10, 1'b0, 8'h00, 0, 0, 4);
        idle(1);
        // Read data with no tx_valid: flag stays set.
        frame(1'b1, 10'h301, 10, 1'b0, 8'h00, 3, 0, 0);
        idle(1);

        // Asynchronous reset three bits into serialising FF.
        send_word(1'b1, 10'h3C5, 10, path, aborted);
        check("rd_path_data", 10'(path), 10'd2);
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        exp_miso = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        SS_n = 1'b1;
        #1;
        exp_miso = 1'b0;
        exp_rx_data = 10'h000;
        model_rd = 1'b0;
        check("async_miso", 10'(MISO), 10'd0);
        check("async_rx_data", rx_data, 10'd0);
        check_rd("async_rd");
        tick();
        tick();
        rst_n = 1'b1;
        idle(4);

        // Randomised frames.
        for (int f = 0; f < 60; f++) begin
            int ab;
            int sa;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
            sa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
            frame(1'($urandom), 10'($urandom), ab, ($urandom_range(0, 3) != 0),
                  8'($urandom), int'($urandom_range(0, 3)), sa, int'($urandom_range(0, 3)));
            idle(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
